spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR flash responder: the target-side end of the flash command protocol.
- Oversamples a host's SCLK/CS_n/MOSI on a fast system clock and decodes the P25Q32H command subset READ, FREAD, PP, WREN, RSTEN and RST.
- Serves and stores data through a simple synchronous memory port.
- Used as an on-fabric flash emulator for FPGA-in-the-loop testing of the flash controller, and as a bench model.

Parameters:
- ADDR_W, 22: memory address width; the upper 24-ADDR_W bits of the wire address are ignored.
- DMMY_BYTES, 1: dummy bytes after the FREAD address.
- PAGE_W, 8: page-program wrap width (256-byte pages).

Ports:
- interfaceClk  in  1  system clock; must be at least 8x the SCLK frequency.
- reset_n  in  1  asynchronous active-low reset.
- SCLK  in  1  SPI clock from host, asynchronous, CPOL=1 (mode 3).
- CS_n  in  1  chip select from host, asynchronous.
- MOSI  in  1  serial data from host.
- MISO  out  1  serial data to host.
- MISO_oe  out  1  MISO output enable (1 = drive).
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read strobe, one cycle.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  out  1  write strobe, one cycle.
- mem_wr_data  out  8  write data, qualified by mem_wr_en.
- wel  out  1  write-enable latch.
- busy  out  1  high while CS_n (synchronized) is low.

Behaviour:
- Clocking and reset:
  - Single clock interfaceClk; reset_n asynchronous active-low.
  - Reset values: MISO=1, MISO_oe=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, wel=0, busy=0, FSM=IDLE, all counters 0.
- Input conditioning:
  - SCLK, CS_n and MOSI each pass through a 2-flop synchronizer plus a delay flop.
  - Edge detection produces sck_rise, sck_fall, cs_fall and cs_rise, each a one-cycle pulse.
  - Latency from pin to pulse is 3 cycles.
- Bit timing (mode 3):
  - MOSI is sampled on sck_rise, MSB first.
  - MISO is updated on sck_fall.
  - A bit counter (0-7) increments on each sck_rise; a byte is complete when bit 7 is sampled.
- FSM states: IDLE, CMD, ADDR, DMMY, RD_DATA, WR_DATA, IGNORE.
  - IDLE -> CMD on cs_fall; counters cleared.
  - CMD, on byte complete:
    - READ -> ADDR.
    - FREAD -> ADDR.
    - PP -> ADDR if wel=1, else IGNORE.
    - WREN: sets wel, -> IGNORE.
    - RSTEN: arms rst_armed, -> IGNORE.
    - RST: if rst_armed, clears wel, -> IGNORE.
    - Any other opcode -> IGNORE.
    - rst_armed is cleared by any completed command byte other than RSTEN, and survives only until the next command.
  - ADDR: 3 bytes, MSB first, shifted into a 24-bit register; mem_addr takes the low ADDR_W bits.
    - After the 3rd byte: FREAD -> DMMY; READ -> RD_DATA; PP -> WR_DATA.
  - DMMY: consumes DMMY_BYTES*8 clocks with MOSI ignored and MISO_oe=0, then -> RD_DATA.
  - RD_DATA:
    - mem_rd_en pulses on the cycle the last address bit (READ) or last dummy bit (FREAD) is sampled.
    - mem_rd_data is loaded into the output shift register the following cycle.
    - MISO_oe goes to 1 on the next sck_fall, which drives bit 7.
    - Each later sck_fall shifts out the next bit.
    - On sampling bit 7 of a byte: mem_addr increments, wrapping at 2^ADDR_W, and the next mem_rd_en issues. The read stream is continuous.
  - WR_DATA:
    - On each completed byte, mem_wr_en pulses for 1 cycle with mem_wr_data = the byte.
    - Then only mem_addr[PAGE_W-1:0] increments; it wraps within the page and the upper bits are held.
  - IGNORE: all SCLK activity is discarded until CS_n rises.
- CS_n rise, in any state:
  - FSM -> IDLE, MISO_oe=0, MISO=1.
  - A partial byte is discarded; no mem_wr_en is issued for it.
  - If the transaction reached WR_DATA, wel clears. This happens even if zero data bytes were written.
  - cs_rise wins over a same-cycle sck_rise.
- Boundary rules:
  - cs_fall while not IDLE (glitch) restarts at CMD.
  - mem_rd_en and mem_wr_en never assert in the same cycle.
  - An asynchronous reset mid-transaction returns to IDLE immediately; the host must deassert CS before retrying.

Decomposition:
- Shared package spi_flash_pkg: opcode constants (READ 8'h03, FREAD 8'h0B, PP 8'h02, WREN 8'h06, RSTEN 8'h66, RST 8'h99) and the FSM state encoding. The controller uses the same constants.
- One sub-module: spi_pin_sync, which does the 2-flop synchronization and edge detection for SCLK and CS_n and syncs MOSI. It outputs sck_rise, sck_fall, cs_fall, cs_rise and mosi_s.

Test Plan:
- READ 03 00 00 10 with memory[0x10..0x12]=A5,3C,FF over 24 data clocks -> MISO bytes A5 3C FF; exactly 3 mem_rd_en at addresses 0x10, 0x11, 0x12; MISO_oe=0 after CS rise.
- FREAD 0B 3F FF FF, 8 dummy clocks, 16 data clocks with memory[0x3FFFFF]=11 and memory[0]=22 -> MISO 11 then 22 (address wrap); MISO_oe=0 during the dummy byte.
- PP 02 00 01 FE with data 01 02 03, no prior WREN -> no mem_wr_en; wel stays 0.
- WREN, then PP 02 00 01 FE with data 01 02 03 -> writes to 0x1FE=01, 0x1FF=02, 0x100=03 (page wrap); wel=0 after CS rise.
- WREN; RSTEN then RST -> wel=0. Also: WREN; RSTEN, READ, RST -> wel stays 1.
- PP with CS_n raised after 4 bits of the second data byte -> exactly 1 mem_wr_en; FSM in IDLE; a subsequent READ works normally. Also: reset_n pulsed mid-READ -> MISO_oe=0 and no memory strobes.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared opcode constants, FSM state encoding and counter widths for the SPI
// flash responder and its controller.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;

    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned BYTE_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DMMY,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    function automatic logic isReadOp(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_FREAD);
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the synchronous memory port of the flash responder.
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              SCLK;
    logic              CS_n;
    logic              MOSI;
    logic              MISO;
    logic              MISO_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport slave (
        input  SCLK, CS_n, MOSI, mem_rd_data,
        output MISO, MISO_oe, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport master (
        output SCLK, CS_n, MOSI, mem_rd_data,
        input  MISO, MISO_oe, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizes the asynchronous SPI pins into interfaceClk and produces
// one-cycle edge pulses for SCLK and CS_n, three cycles after the pin moves.
module spi_pin_sync (
    input  logic interfaceClk,
    input  logic reset_n,
    input  logic SCLK,
    input  logic CS_n,
    input  logic MOSI,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);
    // [0] metastable, [1] synchronized, [2] delayed copy for edge detection
    logic [2:0] sckPipe;
    logic [2:0] csPipe;
    logic [2:0] mosiPipe;

    always_ff @(posedge interfaceClk or negedge reset_n) begin
        if (!reset_n) begin
            sckPipe  <= 3'b111;
            csPipe   <= 3'b111;
            mosiPipe <= 3'b000;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
        end else begin
            sckPipe  <= {sckPipe[1:0], SCLK};
            csPipe   <= {csPipe[1:0], CS_n};
            mosiPipe <= {mosiPipe[1:0], MOSI};
            sck_rise <= sckPipe[1] & ~sckPipe[2];
            sck_fall <= ~sckPipe[1] & sckPipe[2];
            cs_fall  <= ~csPipe[1] & csPipe[2];
            cs_rise  <= csPipe[1] & ~csPipe[2];
        end
    end

    assign mosi_s = mosiPipe[2];

endmodule

// File: rtl/spi_flash_responder.sv
// Target side of the SPI NOR flash protocol (mode 3): decodes READ, FREAD, PP,
// WREN, RSTEN and RST and serves/stores bytes through a synchronous memory port.
module spi_flash_responder #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DMMY_BYTES = 1,
    parameter int unsigned PAGE_W     = 8
) (
    input  logic                 interfaceClk,
    input  logic                 reset_n,
    spi_flash_responder_if.slave bus,
    output logic                 wel,
    output logic                 busy
);
    import spi_flash_pkg::*;

    logic sckRise;
    logic sckFall;
    logic csFall;
    logic csRise;
    logic mosiS;

    spi_pin_sync pinSync (
        .interfaceClk (interfaceClk),
        .reset_n      (reset_n),
        .SCLK         (bus.SCLK),
        .CS_n         (bus.CS_n),
        .MOSI         (bus.MOSI),
        .sck_rise     (sckRise),
        .sck_fall     (sckFall),
        .cs_fall      (csFall),
        .cs_rise      (csRise),
        .mosi_s       (mosiS)
    );

    state_t                  state;
    logic [BIT_CNT_W-1:0]    bitCnt;
    logic [BYTE_CNT_W-1:0]   byteCnt;
    logic [6:0]              shiftIn;
    logic [7:0]              opcode;
    logic [7:0]              shOut;
    logic [ADDR_W-1:0]       memAddr;
    logic [7:0]              memWrData;
    logic                    memRdEn;
    logic                    memWrEn;
    logic                    rdLoad;
    logic                    rstArmed;
    logic                    miso;
    logic                    misoOe;

    logic [7:0] inByte_c;
    logic       byteDone_c;

    assign inByte_c   = {shiftIn, mosiS};
    assign byteDone_c = sckRise && (bitCnt == BIT_CNT_W'(7));

    always_ff @(posedge interfaceClk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bitCnt    <= '0;
            byteCnt   <= '0;
            shiftIn   <= '0;
            opcode    <= '0;
            shOut     <= '0;
            memAddr   <= '0;
            memWrData <= '0;
            memRdEn   <= 1'b0;
            memWrEn   <= 1'b0;
            rdLoad    <= 1'b0;
            rstArmed  <= 1'b0;
            miso      <= 1'b1;
            misoOe    <= 1'b0;
            wel       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            memRdEn <= 1'b0;
            memWrEn <= 1'b0;
            rdLoad  <= memRdEn;
            if (rdLoad) begin
                shOut <= bus.mem_rd_data;
            end
            // Page-program address advances after the write strobe, upper bits held
            if (memWrEn) begin
                memAddr[PAGE_W-1:0] <= memAddr[PAGE_W-1:0] + PAGE_W'(1);
            end

            if (csRise) begin
                state   <= ST_IDLE;
                misoOe  <= 1'b0;
                miso    <= 1'b1;
                bitCnt  <= '0;
                byteCnt <= '0;
                busy    <= 1'b0;
                if (state == ST_WR_DATA) begin
                    wel <= 1'b0;
                end
            end else if (csFall) begin
                state   <= ST_CMD;
                misoOe  <= 1'b0;
                miso    <= 1'b1;
                bitCnt  <= '0;
                byteCnt <= '0;
                busy    <= 1'b1;
            end else begin
                if (sckRise) begin
                    bitCnt  <= bitCnt + BIT_CNT_W'(1);
                    shiftIn <= inByte_c[6:0];
                end
                case (state)
                    ST_CMD: begin
                        if (byteDone_c) begin
                            opcode   <= inByte_c;
                            rstArmed <= (inByte_c == OP_RSTEN);
                            byteCnt  <= '0;
                            state    <= ST_IGNORE;
                            if (isReadOp(inByte_c)) begin
                                state <= ST_ADDR;
                            end else if (inByte_c == OP_PP) begin
                                if (wel) begin
                                    state <= ST_ADDR;
                                end
                            end else if (inByte_c == OP_WREN) begin
                                wel <= 1'b1;
                            end else if (inByte_c == OP_RST) begin
                                if (rstArmed) begin
                                    wel <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        // Address bits shift straight into mem_addr; the top wire bits fall off
                        if (sckRise) begin
                            memAddr <= {memAddr[ADDR_W-2:0], mosiS};
                        end
                        if (byteDone_c) begin
                            byteCnt <= byteCnt + BYTE_CNT_W'(1);
                            if (byteCnt == BYTE_CNT_W'(2)) begin
                                byteCnt <= '0;
                                if (opcode == OP_PP) begin
                                    state <= ST_WR_DATA;
                                end else if ((opcode == OP_FREAD) && (DMMY_BYTES != 0)) begin
                                    state <= ST_DMMY;
                                end else begin
                                    state   <= ST_RD_DATA;
                                    memRdEn <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DMMY: begin
                        if (byteDone_c) begin
                            byteCnt <= byteCnt + BYTE_CNT_W'(1);
                            if (byteCnt == BYTE_CNT_W'(DMMY_BYTES - 1)) begin
                                state   <= ST_RD_DATA;
                                memRdEn <= 1'b1;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (sckFall) begin
                            miso   <= shOut[7];
                            shOut  <= {shOut[6:0], 1'b1};
                            misoOe <= 1'b1;
                        end
                        if (byteDone_c) begin
                            memAddr <= memAddr + ADDR_W'(1);
                            memRdEn <= 1'b1;
                        end
                    end
                    ST_WR_DATA: begin
                        if (byteDone_c) begin
                            memWrEn   <= 1'b1;
                            memWrData <= inByte_c;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.MISO        = miso;
    assign bus.MISO_oe     = misoOe;
    assign bus.mem_addr    = memAddr;
    assign bus.mem_rd_en   = memRdEn;
    assign bus.mem_wr_en   = memWrEn;
    assign bus.mem_wr_data = memWrData;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: a bit-banged mode-3 host, a
// byte memory model, and queues of expected strobes and MISO bytes.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned HALF   = 8;

    logic interfaceClk = 1'b0;
    logic reset_n;
    logic wel;
    logic busy;

    always #5 interfaceClk = ~interfaceClk;

    spi_flash_responder_if #(.ADDR_W(ADDR_W)) bus();

    spi_flash_responder #(
        .ADDR_W     (ADDR_W),
        .DMMY_BYTES (1),
        .PAGE_W     (8)
    ) dut (
        .interfaceClk (interfaceClk),
        .reset_n      (reset_n),
        .bus          (bus),
        .wel          (wel),
        .busy         (busy)
    );

    int          checkCnt = 0;
    int          failCnt  = 0;
    int          rdSeen   = 0;
    int          rdPushed = 0;
    int          wrSeen   = 0;
    int          wrPushed = 0;
    logic [31:0] rdQ[$];
    logic [31:0] wrQ[$];
    logic [7:0]  misoQ[$];
    logic [7:0]  memArr[int unsigned];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: read data valid exactly one cycle after the strobe
    always @(posedge interfaceClk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= memArr.exists(32'(bus.mem_addr)) ? memArr[32'(bus.mem_addr)] : 8'hFF;
        end
    end

    always @(posedge interfaceClk) begin
        if (bus.mem_wr_en) begin
            memArr[32'(bus.mem_addr)] = bus.mem_wr_data;
        end
    end

    // Strobe monitor pops the expected address/data for every strobe seen
    always @(negedge interfaceClk) begin
        if (bus.mem_rd_en || bus.mem_wr_en) begin
            checkEq("strobe_exclusive", 32'(bus.mem_rd_en & bus.mem_wr_en), 32'd0);
        end
        if (bus.mem_rd_en) begin
            rdSeen++;
            if (rdQ.size() > 0) checkEq("rd_addr", 32'(bus.mem_addr), rdQ.pop_front());
        end
        if (bus.mem_wr_en) begin
            wrSeen++;
            if (wrQ.size() > 0) checkEq("wr_addr_data", {2'b00, bus.mem_addr, bus.mem_wr_data}, wrQ.pop_front());
        end
    end

    task automatic pushRd(input logic [31:0] a);
        rdQ.push_back(a);
        rdPushed++;
    endtask

    task automatic pushWr(input logic [31:0] a, input logic [7:0] d);
        wrQ.push_back({a[23:0], d});
        wrPushed++;
    endtask

    task automatic drainCheck(input string tag);
        checkEq({tag, "_rd_count"}, 32'(rdSeen), 32'(rdPushed));
        checkEq({tag, "_wr_count"}, 32'(wrSeen), 32'(wrPushed));
    endtask

    // One mode-3 bit per iteration: drive on the low phase, sample MISO just before the rise
    task automatic spiBits(input logic [7:0] tx, input int nBits, input bit csAtLast,
                           output logic [7:0] rx, output logic oeSeen);
        rx     = 8'h00;
        oeSeen = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = tx[7-i];
            repeat (HALF) @(negedge interfaceClk);
            rx[7-i] = bus.MISO;
            oeSeen  = oeSeen | bus.MISO_oe;
            bus.SCLK = 1'b1;
            if (csAtLast && (i == nBits - 1)) bus.CS_n = 1'b1;
            repeat (HALF) @(negedge interfaceClk);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [7:0] rx;
        logic       oe;
        spiBits(b, 8, 1'b0, rx, oe);
    endtask

    // Final rising edge may coincide with CS rise so no read prefetch follows
    task automatic readByte(input string tag, input bit csAtLast);
        logic [7:0] rx;
        logic       oe;
        spiBits(8'h00, 8, csAtLast, rx, oe);
        if (misoQ.size() > 0) checkEq(tag, 32'(rx), 32'(misoQ.pop_front()));
    endtask

    task automatic csLow();
        bus.CS_n = 1'b0;
        repeat (HALF) @(negedge interfaceClk);
    endtask

    task automatic csHigh();
        bus.CS_n = 1'b1;
        repeat (2 * HALF) @(negedge interfaceClk);
    endtask

    task automatic singleCmd(input logic [7:0] op);
        csLow();
        sendByte(op);
        csHigh();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic       oe;

        bus.SCLK        = 1'b1;
        bus.CS_n        = 1'b1;
        bus.MOSI        = 1'b0;
        bus.mem_rd_data = 8'h00;
        reset_n         = 1'b0;
        repeat (4) @(negedge interfaceClk);
        checkEq("rst_miso", 32'(bus.MISO), 32'd1);
        checkEq("rst_miso_oe", 32'(bus.MISO_oe), 32'd0);
        checkEq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkEq("rst_wel", 32'(wel), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge interfaceClk);
        checkEq("idle_rd_en", 32'(bus.mem_rd_en), 32'd0);
        checkEq("idle_wr_en", 32'(bus.mem_wr_en), 32'd0);

        // READ with three data bytes
        memArr[32'h10] = 8'hA5;
        memArr[32'h11] = 8'h3C;
        memArr[32'h12] = 8'hFF;
        pushRd(32'h10); pushRd(32'h11); pushRd(32'h12);
        misoQ.push_back(8'hA5); misoQ.push_back(8'h3C); misoQ.push_back(8'hFF);
        csLow();
        sendByte(OP_READ);
        checkEq("read_busy", 32'(busy), 32'd1);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        readByte("read_b0", 1'b0);
        readByte("read_b1", 1'b0);
        readByte("read_b2", 1'b1);
        csHigh();
        checkEq("read_oe_after", 32'(bus.MISO_oe), 32'd0);
        checkEq("read_miso_after", 32'(bus.MISO), 32'd1);
        checkEq("read_busy_after", 32'(busy), 32'd0);
        drainCheck("read");

        // FREAD across the top of the address space
        memArr[32'h3FFFFF] = 8'h11;
        memArr[32'h0]      = 8'h22;
        pushRd(32'h3FFFFF); pushRd(32'h0);
        misoQ.push_back(8'h11); misoQ.push_back(8'h22);
        csLow();
        sendByte(OP_FREAD);
        sendByte(8'h3F); sendByte(8'hFF); sendByte(8'hFF);
        spiBits(8'h00, 8, 1'b0, rx, oe);
        checkEq("fread_dummy_oe", 32'(oe), 32'd0);
        readByte("fread_b0", 1'b0);
        readByte("fread_b1_wrap", 1'b1);
        csHigh();
        checkEq("fread_oe_after", 32'(bus.MISO_oe), 32'd0);
        drainCheck("fread");

        // PP without WREN is ignored
        csLow();
        sendByte(OP_PP);
        sendByte(8'h00); sendByte(8'h01); sendByte(8'hFE);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03);
        csHigh();
        checkEq("pp_nowren_wel", 32'(wel), 32'd0);
        drainCheck("pp_nowren");

        // WREN then PP wrapping inside the page
        singleCmd(OP_WREN);
        checkEq("wren_wel", 32'(wel), 32'd1);
        pushWr(32'h1FE, 8'h01); pushWr(32'h1FF, 8'h02); pushWr(32'h100, 8'h03);
        csLow();
        sendByte(OP_PP);
        sendByte(8'h00); sendByte(8'h01); sendByte(8'hFE);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03);
        checkEq("pp_wel_during", 32'(wel), 32'd1);
        csHigh();
        checkEq("pp_wel_after", 32'(wel), 32'd0);
        drainCheck("pp");

        // RSTEN then RST clears wel
        singleCmd(OP_WREN);
        singleCmd(OP_RSTEN);
        checkEq("rsten_wel", 32'(wel), 32'd1);
        singleCmd(OP_RST);
        checkEq("rst_seq_wel", 32'(wel), 32'd0);

        // An intervening command disarms RST
        singleCmd(OP_WREN);
        singleCmd(OP_RSTEN);
        singleCmd(OP_READ);
        singleCmd(OP_RST);
        checkEq("rst_disarmed_wel", 32'(wel), 32'd1);
        drainCheck("rst");

        // PP aborted mid-byte: only the complete byte is written
        pushWr(32'h20, 8'h5A);
        csLow();
        sendByte(OP_PP);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h20);
        sendByte(8'h5A);
        spiBits(8'hA5, 4, 1'b0, rx, oe);
        csHigh();
        checkEq("abort_busy", 32'(busy), 32'd0);
        checkEq("abort_wel", 32'(wel), 32'd0);
        checkEq("abort_oe", 32'(bus.MISO_oe), 32'd0);
        drainCheck("abort");

        pushRd(32'h20);
        misoQ.push_back(8'h5A);
        csLow();
        sendByte(OP_READ);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h20);
        readByte("after_abort_read", 1'b1);
        csHigh();
        drainCheck("after_abort");

        // Asynchronous reset in the middle of a READ
        pushRd(32'h10);
        csLow();
        sendByte(OP_READ);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        spiBits(8'h00, 3, 1'b0, rx, oe);
        checkEq("midrd_oe_before", 32'(bus.MISO_oe), 32'd1);
        reset_n = 1'b0;
        repeat (3) @(negedge interfaceClk);
        checkEq("midrd_rst_oe", 32'(bus.MISO_oe), 32'd0);
        checkEq("midrd_rst_miso", 32'(bus.MISO), 32'd1);
        checkEq("midrd_rst_addr", 32'(bus.mem_addr), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge interfaceClk);
        checkEq("midrd_post_oe", 32'(bus.MISO_oe), 32'd0);
        csHigh();
        checkEq("midrd_busy", 32'(busy), 32'd0);
        drainCheck("midrd");

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
